// File: rtl/ctrl_pulse_rx.sv
// rtl/ctrl_pulse_rx.sv - clk_dest receiver turning synchronized control levels into queued events (option: CTRL_PULSE_RX_FILTER_EN)
module ctrl_pulse_rx #(
    parameter int CNT_W      = 4,
    parameter int HIGH_W     = 8,
    parameter int MAX_HIGH   = 200,
    parameter int FILTER_LEN = 3
) (
    input  logic             clk_dest,
    input  logic             rst_dest_n,
    input  logic             ctrl_lvl_i,
    output logic             evt_valid_o,
    input  logic             evt_ready_i,
    output logic             evt_pulse_o,
    output logic [CNT_W-1:0] pend_cnt_o,
    output logic             ovf_o,
    output logic             stuck_o,
    input  logic             clr_err_i
);

    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_STUCK} state_t;

    generate
        if (FILTER_LEN < 1) begin : g_bad_filter
            $error("ctrl_pulse_rx: FILTER_LEN must be >= 1");
        end
        if (MAX_HIGH >= (1 << HIGH_W)) begin : g_bad_high
            $error("ctrl_pulse_rx: MAX_HIGH must fit in HIGH_W bits");
        end
    endgenerate

    logic              lvl_f;
    logic              lvl_q;
    logic              rise;
    state_t            state, state_nxt;
    logic [HIGH_W-1:0] hi_cnt, hi_nxt;
    logic              inc;
    logic              dec;
    logic              full;
    logic              stuck_set;
    logic              ovf_set;

`ifdef CTRL_PULSE_RX_FILTER_EN
    localparam int FLT_W = $clog2(FILTER_LEN + 1);
    logic [FLT_W-1:0] flt_cnt;

    // lvl_f flips only once the input has disagreed with it FILTER_LEN cycles in a row
    always_ff @(posedge clk_dest or negedge rst_dest_n) begin
        if (!rst_dest_n) begin
            lvl_f   <= 1'b0;
            flt_cnt <= '0;
        end else if (ctrl_lvl_i != lvl_f) begin
            if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
                lvl_f   <= ctrl_lvl_i;
                flt_cnt <= '0;
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end else begin
            flt_cnt <= '0;
        end
    end
`else
    always_ff @(posedge clk_dest or negedge rst_dest_n) begin
        if (!rst_dest_n) begin
            lvl_f <= 1'b0;
        end else begin
            lvl_f <= ctrl_lvl_i;
        end
    end
`endif

    assign rise = lvl_f & ~lvl_q;

    always_ff @(posedge clk_dest or negedge rst_dest_n) begin
        if (!rst_dest_n) begin
            lvl_q  <= 1'b0;
            state  <= S_IDLE;
            hi_cnt <= '0;
        end else begin
            lvl_q  <= lvl_f;
            state  <= state_nxt;
            hi_cnt <= hi_nxt;
        end
    end

    // hi_cnt holds the number of high cycles already completed, so the rise cycle loads 1
    always_comb begin
        state_nxt = state;
        hi_nxt    = hi_cnt;
        inc       = 1'b0;
        stuck_set = 1'b0;
        case (state)
            S_IDLE: begin
                hi_nxt = '0;
                if (rise) begin
                    inc       = 1'b1;
                    state_nxt = S_HIGH;
                    hi_nxt    = HIGH_W'(1);
                end
            end
            S_HIGH: begin
                if (!lvl_f) begin
                    state_nxt = S_IDLE;
                    hi_nxt    = '0;
                end else if (hi_cnt == HIGH_W'(MAX_HIGH)) begin
                    state_nxt = S_STUCK;
                    stuck_set = 1'b1;
                end else begin
                    hi_nxt = hi_cnt + 1'b1;
                end
            end
            S_STUCK: begin
                if (!lvl_f) begin
                    state_nxt = S_IDLE;
                    hi_nxt    = '0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                hi_nxt    = '0;
            end
        endcase
    end

    assign evt_valid_o = (pend_cnt_o != '0);
    assign dec         = evt_valid_o & evt_ready_i;
    assign full        = &pend_cnt_o;
    assign ovf_set     = inc & ~dec & full;

    always_ff @(posedge clk_dest or negedge rst_dest_n) begin
        if (!rst_dest_n) begin
            pend_cnt_o  <= '0;
            evt_pulse_o <= 1'b0;
            ovf_o       <= 1'b0;
            stuck_o     <= 1'b0;
        end else begin
            evt_pulse_o <= inc;
            if (inc && !dec && !full) begin
                pend_cnt_o <= pend_cnt_o + 1'b1;
            end else if (dec && !inc) begin
                pend_cnt_o <= pend_cnt_o - 1'b1;
            end
            // a set in the same cycle as clr_err_i keeps the flag high
            ovf_o   <= ovf_set   | (ovf_o   & ~clr_err_i);
            stuck_o <= stuck_set | (stuck_o & ~clr_err_i);
        end
    end

endmodule

// File: tb/tb_ctrl_pulse_rx.sv
// tb/tb_ctrl_pulse_rx.sv - self-checking bench for ctrl_pulse_rx
module tb_ctrl_pulse_rx;

    localparam int MAX_HIGH   = 200;
    localparam int FILTER_LEN = 3;
    localparam int CNT_MAX    = 15;

    logic       clk_dest    = 1'b0;
    logic       rst_dest_n  = 1'b0;
    logic       ctrl_lvl_i  = 1'b0;
    logic       evt_ready_i = 1'b0;
    logic       clr_err_i   = 1'b0;
    logic       evt_valid_o;
    logic       evt_pulse_o;
    logic [3:0] pend_cnt_o;
    logic       ovf_o;
    logic       stuck_o;

    ctrl_pulse_rx #(
        .CNT_W(4), .HIGH_W(8), .MAX_HIGH(MAX_HIGH), .FILTER_LEN(FILTER_LEN)
    ) dut (
        .clk_dest   (clk_dest),
        .rst_dest_n (rst_dest_n),
        .ctrl_lvl_i (ctrl_lvl_i),
        .evt_valid_o(evt_valid_o),
        .evt_ready_i(evt_ready_i),
        .evt_pulse_o(evt_pulse_o),
        .pend_cnt_o (pend_cnt_o),
        .ovf_o      (ovf_o),
        .stuck_o    (stuck_o),
        .clr_err_i  (clr_err_i)
    );

    always #5 clk_dest = ~clk_dest;

    int tests = 0;
    int fails = 0;
    int pulse_seen = 0;
    int pend_max = 0;

    // Reference model: filtered level derived from a sample history, events from level edges,
    // queue depth as a saturating integer, stuck from the length of the current high run.
    int m_cnt = 0;
    int m_run = 0;
    bit m_pulse = 0, m_ovf = 0, m_stuck = 0, m_lvl_f = 0, m_lvl_prev = 0;
    bit m_hist[FILTER_LEN];
    bit m_rise, m_dec, m_lvl_new, m_all_diff, m_ovf_set, m_stuck_set;

    always @(posedge clk_dest or negedge rst_dest_n) begin
        if (!rst_dest_n) begin
            m_cnt = 0; m_run = 0; m_pulse = 0; m_ovf = 0; m_stuck = 0;
            m_lvl_f = 0; m_lvl_prev = 0;
            foreach (m_hist[i]) m_hist[i] = 0;
        end else begin
            m_rise      = m_lvl_f && !m_lvl_prev;
            m_dec       = (m_cnt != 0) && evt_ready_i;
            m_ovf_set   = m_rise && !m_dec && (m_cnt == CNT_MAX);
            m_stuck_set = m_lvl_f && (m_run == MAX_HIGH + 1);
            m_pulse     = m_rise;
            if (m_rise && !m_dec && m_cnt < CNT_MAX) m_cnt++;
            else if (m_dec && !m_rise) m_cnt--;
            m_ovf   = m_ovf_set   ? 1'b1 : (clr_err_i ? 1'b0 : m_ovf);
            m_stuck = m_stuck_set ? 1'b1 : (clr_err_i ? 1'b0 : m_stuck);
            for (int i = 0; i < FILTER_LEN - 1; i++) m_hist[i] = m_hist[i+1];
            m_hist[FILTER_LEN-1] = ctrl_lvl_i;
`ifdef CTRL_PULSE_RX_FILTER_EN
            m_all_diff = 1;
            foreach (m_hist[i]) if (m_hist[i] == m_lvl_f) m_all_diff = 0;
            m_lvl_new = m_all_diff ? ctrl_lvl_i : m_lvl_f;
`else
            m_lvl_new = ctrl_lvl_i;
`endif
            m_run      = m_lvl_new ? m_run + 1 : 0;
            m_lvl_prev = m_lvl_f;
            m_lvl_f    = m_lvl_new;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk_dest);
        chk("valid", int'(evt_valid_o), int'(m_cnt != 0));
        chk("pend",  int'(pend_cnt_o), m_cnt);
        chk("pulse", int'(evt_pulse_o), int'(m_pulse));
        chk("ovf",   int'(ovf_o), int'(m_ovf));
        chk("stuck", int'(stuck_o), int'(m_stuck));
        if (evt_pulse_o) pulse_seen++;
        if (int'(pend_cnt_o) > pend_max) pend_max = int'(pend_cnt_o);
    endtask

    task automatic drive(input bit lvl, input int n);
        ctrl_lvl_i = lvl;
        repeat (n) tick();
    endtask

    task automatic clr_pulse();
        clr_err_i = 1'b1;
        tick();
        clr_err_i = 1'b0;
    endtask

    int seg_len;
    bit seg_lvl;
    int ready_bias;

    initial begin
        repeat (3) tick();
        chk("rst_pend", int'(pend_cnt_o), 0);
        chk("rst_valid", int'(evt_valid_o), 0);
        rst_dest_n = 1'b1;

        // single event with consumer ready
        evt_ready_i = 1'b1;
        pulse_seen = 0; pend_max = 0;
        drive(1, 5); drive(0, 6);
        chk("t1_pulses", pulse_seen, 1);
        chk("t1_pend_max", pend_max, 1);
        chk("t1_pend_end", int'(pend_cnt_o), 0);
        chk("t1_ovf", int'(ovf_o), 0);

        // saturation and overflow
        evt_ready_i = 1'b0;
        pulse_seen = 0;
        repeat (16) begin drive(1, 4); drive(0, 4); end
        chk("t2_pend_full", int'(pend_cnt_o), 15);
        chk("t2_ovf_set", int'(ovf_o), 1);
        chk("t2_pulses", pulse_seen, 16);
        clr_pulse(); tick();
        chk("t2_ovf_clr", int'(ovf_o), 0);
        chk("t2_pend_hold", int'(pend_cnt_o), 15);
        evt_ready_i = 1'b1;
        repeat (20) tick();
        chk("t2_drained", int'(pend_cnt_o), 0);

        // simultaneous inc and dec
        evt_ready_i = 1'b0;
        repeat (3) begin drive(1, 4); drive(0, 4); end
        chk("t3_pend3", int'(pend_cnt_o), 3);
        ctrl_lvl_i = 1'b1;
`ifdef CTRL_PULSE_RX_FILTER_EN
        repeat (FILTER_LEN) tick();
`else
        tick();
`endif
        evt_ready_i = 1'b1;
        tick();
        evt_ready_i = 1'b0;
        chk("t3_pend_same", int'(pend_cnt_o), 3);
        chk("t3_pulse", int'(evt_pulse_o), 1);
        drive(1, 2); drive(0, 5);
        evt_ready_i = 1'b1;
        repeat (10) tick();

        // high-time supervision boundary
        pulse_seen = 0;
        drive(1, MAX_HIGH + 1); drive(0, 6);
        chk("t4_stuck", int'(stuck_o), 1);
        chk("t4_one_evt", pulse_seen, 1);
        clr_pulse();
        pulse_seen = 0;
        drive(1, MAX_HIGH); drive(0, 6);
        chk("t4_no_stuck", int'(stuck_o), 0);
        chk("t4_one_evt_b", pulse_seen, 1);

        // glitch handling
        pulse_seen = 0;
        drive(1, 2); drive(0, 8);
`ifdef CTRL_PULSE_RX_FILTER_EN
        chk("t5_glitch", pulse_seen, 0);
`else
        chk("t5_glitch", pulse_seen, 1);
`endif
        pulse_seen = 0;
        drive(1, 3); drive(0, 8);
        chk("t5_three", pulse_seen, 1);

        // asynchronous reset mid-operation
        evt_ready_i = 1'b0;
        repeat (4) begin drive(1, 4); drive(0, 4); end
        drive(1, MAX_HIGH + 5);
        chk("t6_pend5", int'(pend_cnt_o), 5);
        chk("t6_stuck", int'(stuck_o), 1);
        #2 rst_dest_n = 1'b0;
        #1;
        chk("t6_rst_pend", int'(pend_cnt_o), 0);
        chk("t6_rst_valid", int'(evt_valid_o), 0);
        chk("t6_rst_stuck", int'(stuck_o), 0);
        chk("t6_rst_pulse", int'(evt_pulse_o), 0);
        chk("t6_rst_ovf", int'(ovf_o), 0);
        ctrl_lvl_i = 1'b0;
        repeat (2) tick();
        rst_dest_n = 1'b1;
        tick();

        // randomized traffic against the model
        seg_lvl = 0;
        for (int s = 0; s < 500; s++) begin
            seg_lvl    = ~seg_lvl;
            seg_len    = (($urandom % 25) == 0) ? $urandom_range(195, 210) : $urandom_range(1, 6);
            ready_bias = $urandom_range(0, 4);
            ctrl_lvl_i = seg_lvl;
            for (int c = 0; c < seg_len; c++) begin
                evt_ready_i = (($urandom % 4) < ready_bias);
                clr_err_i   = (($urandom % 40) == 0);
                tick();
            end
        end
        clr_err_i = 1'b0;
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
